// File: rtl/trace_defs.sv
// Shared definitions for the architectural-write trace path: event kinds,
// counter width and the bit layout of one buffered trace entry.
package trace_defs;

  localparam logic EV_GRF = 1'b0;
  localparam logic EV_DM  = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DROP_W = 16;

  // Entry layout, LSB first: data | addr | pc | kind.
  localparam int DATA_LSB = 0;

  function automatic int addr_lsb(input int data_w);
    return DATA_LSB + data_w;
  endfunction

  function automatic int pc_lsb(input int data_w);
    return addr_lsb(data_w) + ADDR_W;
  endfunction

  function automatic int kind_bit(input int pc_w, input int data_w);
    return pc_lsb(data_w) + pc_w;
  endfunction

  function automatic int entry_w(input int pc_w, input int data_w);
    return 1 + pc_w + ADDR_W + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Circular buffer accepting up to two writes and one read per cycle.
// push1 is only meaningful together with push0; wdata0 is the older entry.
module trace_fifo_2w1r #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 97
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  logic                     push1,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    wr_ptr_p1;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign wr_ptr_p1 = wr_ptr + AW'(1);
  assign do_pop    = pop && (count != '0);

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are live, so clearing the data would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]    <= wdata0;
    if (push1) mem[wr_ptr_p1] <= wdata1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures GRF writeback and DM store events from the core, keeps them in
// program order and streams them out one per cycle; drops on overflow.
module wb_trace_fifo
  import trace_defs::*;
#(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grf_we,
  input  logic [PC_W-1:0]          grf_pc,
  input  logic [4:0]               grf_addr,
  input  logic [DATA_W-1:0]        grf_wd,
  input  logic                     dm_we,
  input  logic [PC_W-1:0]          dm_pc,
  input  logic [31:0]              dm_addr,
  input  logic [DATA_W-1:0]        dm_wd,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic                     ev_kind,
  output logic [PC_W-1:0]          ev_pc,
  output logic [31:0]              ev_addr,
  output logic [DATA_W-1:0]        ev_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              dropped
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int ENTRY_W  = entry_w(PC_W, DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int PC_LSB   = pc_lsb(DATA_W);
  localparam int KIND_BIT = kind_bit(PC_W, DATA_W);

  logic               grf_cand;
  logic               dm_cand;
  logic [1:0]         n_cand;
  logic [1:0]         n_acc;
  logic [1:0]         n_drop;
  logic [CW-1:0]      free;
  logic               push0;
  logic               push1;
  logic [ENTRY_W-1:0] grf_entry;
  logic [ENTRY_W-1:0] dm_entry;
  logic [ENTRY_W-1:0] wdata0;
  logic [ENTRY_W-1:0] head;
  logic               pop;
  logic [DROP_W:0]    drop_sum;

  // Writes to $0 are architecturally invisible and never traced.
  assign grf_cand = grf_we && (grf_addr != 5'd0);
  assign dm_cand  = dm_we;
  assign n_cand   = {1'b0, grf_cand} + {1'b0, dm_cand};

  // Room is judged on the occupancy at cycle start; a same-cycle pop does not help.
  assign free = CW'(DEPTH) - count;

  // NOTE: n_acc gets a default before any branch so this combinational block
  // cannot infer a latch on a path that skips the assignment.
  always_comb begin
    n_acc = 2'd0;
    if (free >= CW'(2))
      n_acc = n_cand;
    else if (free == CW'(1))
      n_acc = (n_cand != 2'd0) ? 2'd1 : 2'd0;
  end

  assign n_drop = n_cand - n_acc;
  assign push0  = (n_acc != 2'd0);
  assign push1  = (n_acc == 2'd2);

  assign grf_entry = {EV_GRF, grf_pc, {(ADDR_W-5){1'b0}}, grf_addr, grf_wd};
  assign dm_entry  = {EV_DM, dm_pc, dm_addr, dm_wd};

  // The WB instruction is older than the MEM one, so GRF always goes first.
  assign wdata0 = grf_cand ? grf_entry : dm_entry;

  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push0  (push0),
    .push1  (push1),
    .wdata0 (wdata0),
    .wdata1 (dm_entry),
    .pop    (pop),
    .rdata  (head),
    .count  (count)
  );

  // Drop accounting saturates instead of wrapping so a long overrun stays visible.
  assign drop_sum = {1'b0, dropped} + (DROP_W+1)'(n_drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (n_drop != 2'd0) begin
      overflow <= 1'b1;
      dropped  <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

  // Fields read as zero while empty so stale storage never leaks out.
  always_comb begin
    ev_kind = 1'b0;
    ev_pc   = '0;
    ev_addr = '0;
    ev_data = '0;
    if (ev_valid) begin
      ev_kind = head[KIND_BIT];
      ev_pc   = head[PC_LSB +: PC_W];
      ev_addr = head[ADDR_LSB +: ADDR_W];
      ev_data = head[DATA_LSB +: DATA_W];
    end
  end

endmodule
